// File: rtl/sd_buf_pair.sv
// rtl/sd_buf_pair.sv - two-stage srdy/drdy elastic buffer: skid input stage plus registered output stage
module sd_buf_pair #(
    parameter int width = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             c_srdy,
    output logic             c_drdy,
    input  logic [width-1:0] c_data,
    output logic             p_srdy,
    input  logic             p_drdy,
    output logic [width-1:0] p_data,
    output logic [1:0]       usage
);

    logic [width-1:0] hold_q, hold_d;
    logic             hold_v_q, hold_v_d;
    logic             c_drdy_q, c_drdy_d;
    logic [width-1:0] p_data_q, p_data_d;
    logic             p_srdy_q, p_srdy_d;

    logic             c_xfer;
    logic             i_srdy;
    logic             i_drdy;
    logic [width-1:0] i_data;

    always_comb begin
        c_xfer = c_srdy & c_drdy_q;
        // The skid entry is always older than whatever is on c_data.
        i_srdy = hold_v_q | c_xfer;
        i_data = hold_v_q ? hold_q : c_data;
        i_drdy = !p_srdy_q | p_drdy;

        p_data_d = p_data_q;
        p_srdy_d = p_srdy_q;
        hold_d   = hold_q;
        hold_v_d = hold_v_q;

        if (i_srdy && i_drdy) begin
            p_data_d = i_data;
            p_srdy_d = 1'b1;
        end else if (p_drdy) begin
            p_srdy_d = 1'b0;
        end

        if (c_xfer && !i_drdy) begin
            hold_d   = c_data;
            hold_v_d = 1'b1;
        end else if (hold_v_q && i_drdy) begin
            hold_v_d = 1'b0;
        end

        if (clear) begin
            p_data_d = p_data_q;
            p_srdy_d = 1'b0;
            hold_d   = hold_q;
            hold_v_d = 1'b0;
        end

        // Ready drops while the skid is full, so capture and drain never overlap.
        c_drdy_d = !hold_v_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_q   <= '0;
            hold_v_q <= 1'b0;
            c_drdy_q <= 1'b1;
            p_data_q <= '0;
            p_srdy_q <= 1'b0;
        end else begin
            hold_q   <= hold_d;
            hold_v_q <= hold_v_d;
            c_drdy_q <= c_drdy_d;
            p_data_q <= p_data_d;
            p_srdy_q <= p_srdy_d;
        end
    end

    assign c_drdy = c_drdy_q;
    assign p_srdy = p_srdy_q;
    assign p_data = p_data_q;
    assign usage  = {1'b0, hold_v_q} + {1'b0, p_srdy_q};

endmodule

// File: tb/tb_sd_buf_pair.sv
// tb/tb_sd_buf_pair.sv - directed and randomized-handshake bench for sd_buf_pair
module tb_sd_buf_pair;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       clear = 1'b0;
    logic       c_srdy = 1'b0;
    logic [7:0] c_data = 8'h00;
    logic       p_drdy = 1'b0;
    logic       c_drdy;
    logic       p_srdy;
    logic [7:0] p_data;
    logic [1:0] usage;

    int checks = 0;
    int errors = 0;

    logic [7:0] rx_q[$];
    int         send_idx = 0;
    logic       acc_last = 1'b0;

    sd_buf_pair #(.width(8)) dut (
        .clk    (clk),
        .reset  (reset),
        .clear  (clear),
        .c_srdy (c_srdy),
        .c_drdy (c_drdy),
        .c_data (c_data),
        .p_srdy (p_srdy),
        .p_drdy (p_drdy),
        .p_data (p_data),
        .usage  (usage)
    );

    always #5 clk = ~clk;

    // Handshake monitor: sees pre-edge values at each rising edge.
    always @(posedge clk) begin
        if (reset) begin
            acc_last <= c_srdy & c_drdy & !clear;
            if (c_srdy && c_drdy && !clear) send_idx <= send_idx + 1;
            if (p_srdy && p_drdy) rx_q.push_back(p_data);
        end
    end

    task automatic drive(input logic cs, input logic [7:0] cd, input logic pd, input logic cl);
        @(negedge clk);
        c_srdy = cs;
        c_data = cd;
        p_drdy = pd;
        clear  = cl;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive(0, 8'h00, 0, 0);
        drive(0, 8'h00, 0, 0);
        checks++; if (p_srdy !== 1'b0) begin errors++; $display("FAIL rst_p_srdy: got %b want 0", p_srdy); end
        checks++; if (c_drdy !== 1'b1) begin errors++; $display("FAIL rst_c_drdy: got %b want 1", c_drdy); end
        checks++; if (usage !== 2'd0) begin errors++; $display("FAIL rst_usage: got %0d want 0", usage); end
        checks++; if (p_data !== 8'h00) begin errors++; $display("FAIL rst_p_data: got %h want 00", p_data); end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_streaming();
        rx_q.delete();
        for (int k = 0; k <= 16; k++) begin
            drive(k < 16, 8'(k + 1), 1, 0);
            checks++; if (c_drdy !== 1'b1) begin errors++; $display("FAIL stream_c_drdy[%0d]: got %b want 1", k, c_drdy); end
            checks++; if (p_srdy !== (k >= 1)) begin errors++; $display("FAIL stream_p_srdy[%0d]: got %b want %b", k, p_srdy, (k >= 1)); end
            if (k >= 1) begin
                checks++; if (p_data !== 8'(k)) begin errors++; $display("FAIL stream_p_data[%0d]: got %h want %h", k, p_data, 8'(k)); end
            end
            checks++; if (usage > 2'd1) begin errors++; $display("FAIL stream_usage[%0d]: got %0d want <=1", k, usage); end
        end
        drive(0, 8'h00, 1, 0);
        checks++; if (p_srdy !== 1'b0) begin errors++; $display("FAIL stream_drain: got p_srdy %b want 0", p_srdy); end
        checks++; if (rx_q.size() != 16) begin errors++; $display("FAIL stream_count: got %0d want 16", rx_q.size()); end
        for (int k = 0; k < 16 && k < rx_q.size(); k++) begin
            checks++; if (rx_q[k] !== 8'(k + 1)) begin errors++; $display("FAIL stream_seq[%0d]: got %h want %h", k, rx_q[k], 8'(k + 1)); end
        end
    endtask

    task automatic test_backpressure();
        rx_q.delete();
        drive(1, 8'hA1, 0, 0);
        checks++; if (c_drdy !== 1'b1 || p_srdy !== 1'b0) begin errors++; $display("FAIL bp_c0: got c_drdy %b p_srdy %b want 1 0", c_drdy, p_srdy); end
        drive(1, 8'hA2, 0, 0);
        checks++; if (c_drdy !== 1'b1 || p_srdy !== 1'b1 || p_data !== 8'hA1 || usage !== 2'd1) begin
            errors++; $display("FAIL bp_c1: got c_drdy %b p_srdy %b p_data %h usage %0d want 1 1 a1 1", c_drdy, p_srdy, p_data, usage); end
        drive(1, 8'hA3, 0, 0);
        checks++; if (c_drdy !== 1'b0 || usage !== 2'd2 || p_data !== 8'hA1) begin
            errors++; $display("FAIL bp_c2: got c_drdy %b usage %0d p_data %h want 0 2 a1", c_drdy, usage, p_data); end
        drive(1, 8'hA3, 0, 0);
        checks++; if (c_drdy !== 1'b0 || usage !== 2'd2) begin errors++; $display("FAIL bp_c3: got c_drdy %b usage %0d want 0 2", c_drdy, usage); end
        drive(1, 8'hA3, 1, 0);
        checks++; if (c_drdy !== 1'b0 || p_data !== 8'hA1) begin errors++; $display("FAIL bp_c4: got c_drdy %b p_data %h want 0 a1", c_drdy, p_data); end
        drive(1, 8'hA3, 1, 0);
        checks++; if (c_drdy !== 1'b1 || p_data !== 8'hA2 || usage !== 2'd1) begin
            errors++; $display("FAIL bp_c5: got c_drdy %b p_data %h usage %0d want 1 a2 1", c_drdy, p_data, usage); end
        drive(0, 8'h00, 1, 0);
        checks++; if (p_srdy !== 1'b1 || p_data !== 8'hA3) begin errors++; $display("FAIL bp_c6: got p_srdy %b p_data %h want 1 a3", p_srdy, p_data); end
        drive(0, 8'h00, 1, 0);
        checks++; if (p_srdy !== 1'b0 || usage !== 2'd0) begin errors++; $display("FAIL bp_c7: got p_srdy %b usage %0d want 0 0", p_srdy, usage); end
        checks++; if (rx_q.size() != 3) begin errors++; $display("FAIL bp_count: got %0d want 3", rx_q.size()); end
        else if (rx_q[0] !== 8'hA1 || rx_q[1] !== 8'hA2 || rx_q[2] !== 8'hA3) begin
            errors++; $display("FAIL bp_order: got %h %h %h want a1 a2 a3", rx_q[0], rx_q[1], rx_q[2]); end
    endtask

    task automatic test_random();
        int   cyc;
        int   seq_err;
        int   edge_err;
        logic a;
        rx_q.delete();
        send_idx = 0;
        cyc = 0;
        seq_err = 0;
        edge_err = 0;
        while (rx_q.size() < 1000 && cyc < 20000) begin
            @(negedge clk);
            if (!(c_srdy && !acc_last)) c_srdy = (send_idx < 1000) && ($urandom_range(0, 3) != 0);
            c_data = send_idx[7:0];
            p_drdy = ($urandom_range(0, 2) != 0);
            clear  = 1'b0;
            cyc++;
            #1 a = c_drdy;
            #3 if (c_drdy !== a) edge_err++;
        end
        c_srdy = 1'b0;
        checks++; if (cyc >= 20000) begin errors++; $display("FAIL rand_timeout: got %0d words want 1000", rx_q.size()); end
        checks++; if (rx_q.size() != 1000) begin errors++; $display("FAIL rand_count: got %0d want 1000", rx_q.size()); end
        for (int i = 0; i < rx_q.size(); i++) begin
            if (rx_q[i] !== 8'(i)) begin
                if (seq_err == 0) $display("FAIL rand_seq[%0d]: got %h want %h", i, rx_q[i], 8'(i));
                seq_err++;
            end
        end
        checks++; if (seq_err != 0) begin errors++; $display("FAIL rand_seq_total: got %0d bad words want 0", seq_err); end
        checks++; if (edge_err != 0) begin errors++; $display("FAIL rand_c_drdy_glitch: got %0d want 0", edge_err); end
        drive(0, 8'h00, 1, 0);
        drive(0, 8'h00, 1, 0);
        drive(0, 8'h00, 1, 0);
    endtask

    task automatic test_clear();
        rx_q.delete();
        drive(1, 8'h55, 0, 0);
        drive(1, 8'h66, 0, 0);
        drive(1, 8'h77, 0, 0);
        checks++; if (usage !== 2'd2 || p_data !== 8'h55 || c_drdy !== 1'b0) begin
            errors++; $display("FAIL clr_fill: got usage %0d p_data %h c_drdy %b want 2 55 0", usage, p_data, c_drdy); end
        drive(1, 8'h77, 0, 1);
        drive(0, 8'h00, 0, 0);
        checks++; if (p_srdy !== 1'b0 || usage !== 2'd0 || c_drdy !== 1'b1) begin
            errors++; $display("FAIL clr_full: got p_srdy %b usage %0d c_drdy %b want 0 0 1", p_srdy, usage, c_drdy); end
        checks++; if (p_data !== 8'h55) begin errors++; $display("FAIL clr_p_data_hold: got %h want 55", p_data); end
        drive(1, 8'h88, 0, 0);
        drive(1, 8'h99, 0, 1);
        drive(0, 8'h00, 1, 0);
        checks++; if (p_srdy !== 1'b0 || usage !== 2'd0 || c_drdy !== 1'b1 || p_data !== 8'h88) begin
            errors++; $display("FAIL clr_discard: got p_srdy %b usage %0d c_drdy %b p_data %h want 0 0 1 88", p_srdy, usage, c_drdy, p_data); end
        drive(1, 8'hAA, 0, 0);
        drive(0, 8'h00, 1, 1);
        drive(0, 8'h00, 1, 0);
        drive(0, 8'h00, 1, 0);
        checks++; if (rx_q.size() != 1) begin errors++; $display("FAIL clr_rx_count: got %0d want 1", rx_q.size()); end
        else if (rx_q[0] !== 8'hAA) begin errors++; $display("FAIL clr_rx_word: got %h want aa", rx_q[0]); end
    endtask

    task automatic test_async_reset();
        rx_q.delete();
        drive(1, 8'h11, 0, 0);
        drive(1, 8'h22, 0, 0);
        drive(0, 8'h00, 0, 0);
        checks++; if (usage !== 2'd2) begin errors++; $display("FAIL ar_fill: got usage %0d want 2", usage); end
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        checks++; if (p_srdy !== 1'b0 || usage !== 2'd0 || c_drdy !== 1'b1 || p_data !== 8'h00) begin
            errors++; $display("FAIL ar_immediate: got p_srdy %b usage %0d c_drdy %b p_data %h want 0 0 1 00", p_srdy, usage, c_drdy, p_data); end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        drive(1, 8'h33, 1, 0);
        checks++; if (c_drdy !== 1'b1 || p_srdy !== 1'b0) begin errors++; $display("FAIL ar_resume0: got c_drdy %b p_srdy %b want 1 0", c_drdy, p_srdy); end
        drive(0, 8'h00, 1, 0);
        checks++; if (p_srdy !== 1'b1 || p_data !== 8'h33) begin errors++; $display("FAIL ar_resume1: got p_srdy %b p_data %h want 1 33", p_srdy, p_data); end
        drive(0, 8'h00, 1, 0);
        checks++; if (rx_q.size() != 1) begin errors++; $display("FAIL ar_rx_count: got %0d want 1", rx_q.size()); end
        else if (rx_q[0] !== 8'h33) begin errors++; $display("FAIL ar_rx_word: got %h want 33", rx_q[0]); end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_random();
        test_clear();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sd_buf_pair.md
Name: sd_buf_pair

Overview:
- Two-stage srdy/drdy elastic buffer: an input stage followed by an output stage, registered on both ends.
- The input stage is a one-entry skid buffer with a registered c_drdy. The output stage is a one-entry register with registered p_srdy/p_data.
- Used as the read-data buffer behind one-cycle-latency memories in FIFO tails. It decouples producer/consumer timing and sustains one transfer per cycle.

Parameters:
- width, 8, data bus width in bits.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset.
- clear  input  1  synchronous flush, active-high; empties both stages.
- c_srdy  input  1  upstream data valid.
- c_drdy  output  1  upstream ready; driven directly from a flop.
- c_data  input  width  upstream data.
- p_srdy  output  1  downstream data valid; driven directly from a flop.
- p_drdy  input  1  downstream ready.
- p_data  output  width  downstream data; driven directly from a flop.
- usage  output  2  entries held (0..2), = hold_v + p_srdy.

Behaviour:
- Transfer on a port = srdy & drdy in the same cycle. Data must be stable while srdy=1 and drdy=0.
- Internal state:
  - hold/hold_v: skid entry in the input stage.
  - c_drdy flop.
  - p_data/p_srdy: output register.
- Internal link, combinational:
  - i_srdy = hold_v | (c_srdy & c_drdy).
  - i_data = hold_v ? hold : c_data.
  - i_drdy = !p_srdy | p_drdy.
- Output register:
  - If i_srdy & i_drdy: p_data <= i_data, p_srdy <= 1.
  - Else if p_drdy: p_srdy <= 0.
  - p_data holds whenever no load occurs.
- Skid entry:
  - If c_srdy & c_drdy & !i_drdy: hold <= c_data, hold_v <= 1.
  - Else if hold_v & i_drdy: hold_v <= 0.
- c_drdy flop: c_drdy <= !next(hold_v). Because c_drdy=0 while hold_v=1, capture and drain never coincide.
- Priority: hold is always forwarded before new c_data, so order is preserved.
- Latency: word accepted on c in cycle N appears on p_srdy/p_data in cycle N+1 when the output stage is free.
- Throughput: 1 word/cycle with p_drdy held high. Capacity is 2 words.
- Backpressure: with p_drdy=0, the output register and hold fill; c_drdy falls one cycle after the capture. A word presented in the capture cycle is still accepted, because of the skid.
- Reset (reset=0, async): p_srdy=0, hold_v=0, c_drdy=1, usage=0. p_data and hold are cleared to 0.
- Clear (sync, dominates all transfers):
  - Next state p_srdy=0, hold_v=0, c_drdy=1.
  - A word offered on c in a clear cycle is discarded.
  - A p transfer in a clear cycle still counts for the consumer.
- Assertion of reset mid-operation drops all buffered data immediately. Normal operation resumes on the first edge after deassertion.
- No X on outputs after reset. p_data holds its last value when p_srdy=0.

Test Plan:
- Reset then idle: reset low 2 cycles -> p_srdy=0, c_drdy=1, usage=0, p_data=0.
- Streaming: c_srdy=1 with data 0x01..0x10 on consecutive cycles, p_drdy=1 -> p_data 0x01..0x10 on consecutive cycles, each one cycle after acceptance; c_drdy stays 1; usage stays ≤1.
- Backpressure/skid: p_drdy=0, send 0xA1, 0xA2, 0xA3.
  - 0xA1 reaches the output register; 0xA2 is captured in hold.
  - c_drdy=0 from the next cycle, so 0xA3 is not accepted; usage=2.
  - Raise p_drdy -> outputs 0xA1, 0xA2, 0xA3 in order, with no loss or duplication.
- Random srdy/drdy toggling, 1000 words with incrementing data -> the scoreboard receives the exact sequence; c_drdy never changes except at a clock edge.
- Clear with usage=2 (0x55 in output, 0x66 in hold) -> next cycle p_srdy=0, usage=0, c_drdy=1; a word offered during clear never appears.
- Async reset asserted mid-stream between edges -> p_srdy and usage go to 0 immediately, c_drdy=1; traffic resumes cleanly after release.
